// File: rtl/desempacotar_vetores.sv
// rtl/desempacotar_vetores.sv - serial receiver/unpacker for the inverted 6-bit {b,a} vector word (optional parity: DESEMPACOTAR_PARIDADE_EN)
module desempacotar_vetores (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic       palavra_valid,
    input  logic       palavra_ready,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [2:0] saida_or_bit_a_bit,
    output logic       saida_or_logico,
    output logic       erro_paridade
);

`ifdef DESEMPACOTAR_PARIDADE_EN
    typedef enum logic [1:0] {
        RECEBE   = 2'd0,
        PARIDADE = 2'd1,
        CHEIO    = 2'd2
    } estado_t;
`else
    typedef enum logic [1:0] {
        RECEBE = 2'd0,
        CHEIO  = 2'd2
    } estado_t;
`endif

    estado_t    state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] shift_q, shift_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [2:0] or_q, or_d;
    logic       orl_q, orl_d;
    logic       carregar;
`ifdef DESEMPACOTAR_PARIDADE_EN
    logic       err_q, err_d;
`endif

    // Next-state logic: bit capture, frame completion and output handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        a_d      = a_q;
        b_d      = b_q;
        or_d     = or_q;
        orl_d    = orl_q;
        carregar = 1'b0;
`ifdef DESEMPACOTAR_PARIDADE_EN
        err_d    = err_q;
`endif
        case (state_q)
            RECEBE: begin
                if (bit_valid) begin
                    shift_d[cnt_q] = bit_in;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
`ifdef DESEMPACOTAR_PARIDADE_EN
                        state_d  = PARIDADE;
`else
                        state_d  = CHEIO;
                        carregar = 1'b1;
`endif
                    end
                end
            end
`ifdef DESEMPACOTAR_PARIDADE_EN
            PARIDADE: begin
                if (bit_valid) begin
                    state_d  = CHEIO;
                    carregar = 1'b1;
                    // Even parity over data plus parity bit: odd XOR flags an error
                    err_d    = (^shift_q) ^ bit_in;
                end
            end
`endif
            CHEIO: begin
                if (palavra_ready) begin
                    state_d = RECEBE;
                    cnt_d   = 3'd0;
`ifdef DESEMPACOTAR_PARIDADE_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = RECEBE;
                cnt_d   = 3'd0;
            end
        endcase

        // Outputs are only refreshed on entry to CHEIO; shift_d already holds the last data bit
        if (carregar) begin
            a_d   = ~shift_d[2:0];
            b_d   = ~shift_d[5:3];
            or_d  = (~shift_d[2:0]) | (~shift_d[5:3]);
            orl_d = (shift_d[2:0] != 3'b111) || (shift_d[5:3] != 3'b111);
        end
    end

    // State and data registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RECEBE;
            cnt_q   <= 3'd0;
            shift_q <= 6'd0;
            a_q     <= 3'd0;
            b_q     <= 3'd0;
            or_q    <= 3'd0;
            orl_q   <= 1'b0;
`ifdef DESEMPACOTAR_PARIDADE_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            b_q     <= b_d;
            or_q    <= or_d;
            orl_q   <= orl_d;
`ifdef DESEMPACOTAR_PARIDADE_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bit_ready          = !rst && (state_q != CHEIO);
    assign palavra_valid      = (state_q == CHEIO);
    assign a                  = a_q;
    assign b                  = b_q;
    assign saida_or_bit_a_bit = or_q;
    assign saida_or_logico    = orl_q;
`ifdef DESEMPACOTAR_PARIDADE_EN
    assign erro_paridade      = err_q;
`else
    assign erro_paridade      = 1'b0;
`endif

endmodule

// File: tb/tb_desempacotar_vetores.sv
// tb/tb_desempacotar_vetores.sv - scoreboard testbench for desempacotar_vetores
module tb_desempacotar_vetores;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       palavra_valid;
    logic       palavra_ready;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] saida_or_bit_a_bit;
    logic       saida_or_logico;
    logic       erro_paridade;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] ea;
        logic [2:0] eb;
        logic [2:0] eo;
        logic       el;
        logic       ee;
    } exp_t;

    exp_t sb[$];

    desempacotar_vetores dut (
        .clk                (clk),
        .rst                (rst),
        .bit_in             (bit_in),
        .bit_valid          (bit_valid),
        .bit_ready          (bit_ready),
        .palavra_valid      (palavra_valid),
        .palavra_ready      (palavra_ready),
        .a                  (a),
        .b                  (b),
        .saida_or_bit_a_bit (saida_or_bit_a_bit),
        .saida_or_logico    (saida_or_logico),
        .erro_paridade      (erro_paridade)
    );

    always #5 clk = ~clk;

    // Drive one frame LSB first (plus parity bit when compiled in) and push the expected result
    task automatic send_frame(input logic [5:0] w, input logic par, input int gap);
        exp_t e;
        logic [6:0] frame;
        int nbits;
        e.ea = ~w[2:0];
        e.eb = ~w[5:3];
        e.eo = e.ea | e.eb;
        e.el = (e.ea != 3'd0) || (e.eb != 3'd0);
`ifdef DESEMPACOTAR_PARIDADE_EN
        e.ee  = (^w) ^ par;
        nbits = 7;
`else
        e.ee  = 1'b0;
        nbits = 6;
`endif
        sb.push_back(e);
        frame = {par, w};
        for (int i = 0; i < nbits; i++) begin
            int n;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bit_valid = 1'b0;
            end
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = frame[i];
            n = 0;
            while (!bit_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL bit_ready_timeout bit %0d: got %b need 1", i, bit_ready);
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if (palavra_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid: got %b need 1", palavra_valid);
        end
    endtask

    // Wait for a presented word and compare it against the scoreboard head
    task automatic check_word(input string name);
        exp_t e;
        int n = 0;
        while (!palavra_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (palavra_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: palavra_valid got %b need 1", name, palavra_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty need entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (a !== e.ea) begin
            errors++;
            $display("FAIL %s a: got %b need %b", name, a, e.ea);
        end
        checks++;
        if (b !== e.eb) begin
            errors++;
            $display("FAIL %s b: got %b need %b", name, b, e.eb);
        end
        checks++;
        if (saida_or_bit_a_bit !== e.eo) begin
            errors++;
            $display("FAIL %s or_bit_a_bit: got %b need %b", name, saida_or_bit_a_bit, e.eo);
        end
        checks++;
        if (saida_or_logico !== e.el) begin
            errors++;
            $display("FAIL %s or_logico: got %b need %b", name, saida_or_logico, e.el);
        end
        checks++;
        if (erro_paridade !== e.ee) begin
            errors++;
            $display("FAIL %s erro_paridade: got %b need %b", name, erro_paridade, e.ee);
        end
        if (palavra_ready) begin
            @(negedge clk);
            checks++;
            if (palavra_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s valid_pulse: got %b need 0", name, palavra_valid);
            end
            checks++;
            if (bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s bit_ready_after: got %b need 1", name, bit_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bit_valid     = 1'b0;
        bit_in        = 1'b0;
        palavra_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset bit_ready: got %b need 0", bit_ready);
        end
        checks++;
        if ({palavra_valid, a, b, saida_or_bit_a_bit, saida_or_logico, erro_paridade} !== 12'd0) begin
            errors++;
            $display("FAIL reset outputs: got %b%b%b%b%b%b need all 0", palavra_valid, a, b,
                     saida_or_bit_a_bit, saida_or_logico, erro_paridade);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release bit_ready: got %b need 1", bit_ready);
        end
    endtask

    task automatic test_basic();
        palavra_ready = 1'b1;
        send_frame(6'b101010, ^6'b101010, 0);
        check_word("basic_101010");
        send_frame(6'b111111, ^6'b111111, 0);
        check_word("zeros_111111");
    endtask

    task automatic test_backpressure();
        palavra_ready = 1'b0;
        send_frame(6'b101010, ^6'b101010, 0);
        check_word("bp_hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            checks++;
            if (bit_ready !== 1'b0 || palavra_valid !== 1'b1 || a !== 3'b101 || b !== 3'b010) begin
                errors++;
                $display("FAIL bp_stable cycle %0d: got ready=%b valid=%b a=%b b=%b need 0 1 101 010",
                         i, bit_ready, palavra_valid, a, b);
            end
        end
        @(negedge clk);
        bit_valid     = 1'b0;
        palavra_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (palavra_valid !== 1'b0 || bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b need 0 1", palavra_valid, bit_ready);
        end
        send_frame(6'b110001, ^6'b110001, 0);
        check_word("bp_fresh_110001");
    endtask

    task automatic test_gapped();
        palavra_ready = 1'b1;
        send_frame(6'b110001, ^6'b110001, 2);
        check_word("gapped_110001");
    endtask

    task automatic test_reset_mid();
        logic [2:0] part;
        part = 3'b011;
        palavra_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = part[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        checks++;
        if (bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid bit_ready: got %b need 0", bit_ready);
        end
        checks++;
        if ({palavra_valid, a, b, saida_or_bit_a_bit, saida_or_logico, erro_paridade} !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b%b%b%b%b%b need all 0", palavra_valid, a, b,
                     saida_or_bit_a_bit, saida_or_logico, erro_paridade);
        end
        rst = 1'b0;
        send_frame(6'b010101, ^6'b010101, 0);
        check_word("reset_mid_010101");
    endtask

`ifdef DESEMPACOTAR_PARIDADE_EN
    task automatic test_parity();
        palavra_ready = 1'b1;
        send_frame(6'b101010, 1'b1, 0);
        check_word("parity_ok");
        palavra_ready = 1'b0;
        send_frame(6'b101010, 1'b0, 0);
        check_word("parity_bad");
        @(negedge clk);
        palavra_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (erro_paridade !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: got %b need 0", erro_paridade);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_reset_mid();
`ifdef DESEMPACOTAR_PARIDADE_EN
        test_parity();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
